// File: rtl/i4003_pkg.sv
// Shared constants and types for the i4003 shift-chain controller.
package i4003_pkg;

  // Bits per i4003 device.
  localparam int SR_BITS = 10;

  // Controller sequence: idle, cp low phase, cp high phase, completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/i4003_phase_timer.sv
// DIV-cycle phase timer shared by the LOW and HIGH phases of the cp waveform.
// last_clk_o is high on the final clock of a phase; restart_i starts a new phase.
module i4003_phase_timer #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic last_clk_o
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Count clocks within the current phase, saturating at the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_clk_o = (cnt_q == LAST);

endmodule

// File: rtl/i4003_shift_ctrl.sv
// Sequencer for a chain of i4003 shift registers: serialises a parallel word
// onto sr_data/sr_cp while capturing the chain's previous contents from sr_sout.
module i4003_shift_ctrl
  import i4003_pkg::*;
#(
  parameter int CHAIN = 1,
  parameter int DIV   = 2,
  parameter int BLANK = 1,
  localparam int W    = SR_BITS * CHAIN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [W-1:0] ld_data,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         busy,
  output logic         sr_cp,
  output logic         sr_data,
  output logic         sr_e,
  input  logic         sr_sout
);

  localparam int BW = $clog2(W + 1);
  localparam logic [BW-1:0] W_CNT = BW'(W);

  state_e          state_q;
  // The MSB of a word goes straight to sr_data, so tx only holds the rest.
  logic [W-2:0]    tx_q;
  logic [W-1:0]    rx_q;
  logic [W-1:0]    rd_data_q;
  logic [BW-1:0]   bit_cnt_q;
  logic [BW-1:0]   bit_cnt_d;
  logic            sr_cp_q;
  logic            sr_data_q;
  logic            sr_e_q;
  logic            rd_valid_q;
  logic            primed_q;
  logic            last_clk;
  logic            timer_restart;

  assign bit_cnt_d = bit_cnt_q + 1'b1;

  // A new phase begins on every phase boundary and on leaving IDLE.
  assign timer_restart = (state_q == IDLE) || last_clk;

  i4003_phase_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart_i  (timer_restart),
    .last_clk_o (last_clk)
  );

  // Main sequencer with all chain-facing outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      bit_cnt_q  <= '0;
      sr_cp_q    <= 1'b0;
      sr_data_q  <= 1'b0;
      sr_e_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_valid) begin
            tx_q      <= ld_data[W-2:0];
            sr_data_q <= ld_data[W-1];
            bit_cnt_q <= '0;
            sr_cp_q   <= 1'b0;
            if (BLANK != 0) begin
              sr_e_q <= 1'b0;
            end
            state_q   <= LOW;
          end
        end
        LOW: begin
          // Sample the chain output just before the rising cp edge shifts it.
          if (last_clk) begin
            rx_q    <= {rx_q[W-2:0], sr_sout};
            sr_cp_q <= 1'b1;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          // Falling cp edge: sr_data only ever moves together with cp going low.
          if (last_clk) begin
            sr_cp_q   <= 1'b0;
            bit_cnt_q <= bit_cnt_d;
            if (bit_cnt_d < W_CNT) begin
              sr_data_q <= tx_q[W-2];
              tx_q      <= {tx_q[W-3:0], 1'b0};
              state_q   <= LOW;
            end else begin
              rd_data_q  <= rx_q;
              rd_valid_q <= 1'b1;
              primed_q   <= 1'b1;
              sr_e_q     <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          sr_e_q  <= primed_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ld_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign sr_cp    = sr_cp_q;
  assign sr_data  = sr_data_q;
  assign sr_e     = sr_e_q;

endmodule

// File: tb/tb_i4003_shift_ctrl.sv
// Bench for i4003_shift_ctrl: three configurations (CHAIN/DIV/BLANK) each driving
// a behavioural i4003 chain, with a queue-based scoreboard and a separate monitor.
module tb_i4003_shift_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit done_flag [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int CH  = (gi == 1) ? 2 : 1;
    localparam int DV  = (gi == 1) ? 1 : 2;
    localparam int BL  = (gi == 2) ? 0 : 1;
    localparam int W   = 10 * CH;
    localparam int LAT = 2 * DV * W + 1;
    localparam logic [W-1:0] D0 = W'((gi == 1) ? 64'hABCDE : 64'h2A5);
    localparam logic [W-1:0] D1 = W'((gi == 1) ? 64'h00000 : 64'h3FF);

    logic         rst_n = 1'b0;
    logic         ld_valid = 1'b0;
    logic         ld_ready, rd_valid, busy, sr_cp, sr_data, sr_e, sr_sout;
    logic [W-1:0] ld_data = '0;
    logic [W-1:0] rd_data;

    // Behavioural chain: one W-bit shift register clocked by cp, s_out = top bit.
    logic [W-1:0] chain = '0;
    logic [W-1:0] exp_chain = '0;
    logic [W-1:0] word_q[$];
    logic [W-1:0] rd_q[$];
    int           acc_q[$];
    int           pulses = 0;
    int           hi_run = 0;
    bit           exp_primed = 1'b0;
    bit           prev_cp = 1'b0;
    bit           prev_data = 1'b0;

    i4003_shift_ctrl #(
      .CHAIN(CH),
      .DIV  (DV),
      .BLANK(BL)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_valid(ld_valid),
      .ld_ready(ld_ready),
      .ld_data (ld_data),
      .rd_valid(rd_valid),
      .rd_data (rd_data),
      .busy    (busy),
      .sr_cp   (sr_cp),
      .sr_data (sr_data),
      .sr_e    (sr_e),
      .sr_sout (sr_sout)
    );

    always @(posedge sr_cp) chain <= {chain[W-2:0], sr_data};
    assign sr_sout = chain[W-1];

    // Record an accepted load: the read-back is whatever the chain held before.
    task automatic push(input logic [W-1:0] w);
      word_q.push_back(w);
      rd_q.push_back(exp_chain);
      acc_q.push_back(cyc);
      exp_chain = w;
    endtask

    task automatic issue(input logic [W-1:0] w);
      int n = 0;
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = w;
      while (!ld_ready && n < LAT + 10) begin
        @(negedge clk);
        n++;
      end
      if (!ld_ready) chk($sformatf("c%0d accept_timeout", gi), 0, 1);
      else push(w);
      @(negedge clk);
      ld_valid = 1'b0;
      ld_data  = W'($urandom);
    endtask

    task automatic wait_idle();
      int n = 0;
      while ((word_q.size() != 0 || busy) && n < 4 * LAT) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d drain", gi), word_q.size(), 0);
    endtask

    // Hold ld_valid through a whole shift, changing the word mid-way.
    task automatic backpressure(input logic [W-1:0] a, input logic [W-1:0] b);
      int  first;
      bit  got = 1'b0;
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = a;
      for (int n = 0; n < LAT + 10 && !ld_ready; n++) @(negedge clk);
      push(a);
      first = cyc;
      for (int n = 1; n < LAT + 10; n++) begin
        @(negedge clk);
        if (n == LAT / 2) ld_data = b;
        if (ld_ready) begin
          push(b);
          chk($sformatf("c%0d second_accept_cycle", gi), cyc - first, LAT + 1);
          got = 1'b1;
          break;
        end
      end
      if (!got) chk($sformatf("c%0d second_accept_seen", gi), 0, 1);
      @(negedge clk);
      ld_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string where);
      chk($sformatf("c%0d %s sr_cp", gi, where), sr_cp, 0);
      chk($sformatf("c%0d %s sr_data", gi, where), sr_data, 0);
      chk($sformatf("c%0d %s sr_e", gi, where), sr_e, 0);
      chk($sformatf("c%0d %s rd_valid", gi, where), rd_valid, 0);
      chk($sformatf("c%0d %s rd_data", gi, where), rd_data, 0);
      chk($sformatf("c%0d %s busy", gi, where), busy, 0);
      chk($sformatf("c%0d %s ld_ready", gi, where), ld_ready, 1);
    endtask

    // Monitor: waveform rules every cycle, scoreboard pop on rd_valid.
    initial begin
      logic [W-1:0] w, r, cur;
      int a;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          pulses = 0;
          hi_run = 0;
          exp_primed = 1'b0;
          prev_cp = 1'b0;
          prev_data = 1'b0;
        end else begin
          if (sr_data != prev_data) chk($sformatf("c%0d data_moved_with_cp_high", gi), sr_cp, 0);
          if (sr_cp && !prev_cp) begin
            if (word_q.size() != 0 && pulses < W) begin
              cur = word_q[0];
              chk($sformatf("c%0d sr_data_pulse%0d", gi, pulses), sr_data, cur[W-1-pulses]);
            end
            pulses++;
          end
          if (sr_cp) hi_run++;
          else if (prev_cp) begin
            chk($sformatf("c%0d cp_high_width", gi), hi_run, DV);
            hi_run = 0;
          end
          if (rd_valid) chk($sformatf("c%0d sr_e_done", gi), sr_e, 1);
          else if (busy) chk($sformatf("c%0d sr_e_shift", gi), sr_e, (BL != 0) ? 0 : exp_primed);
          else chk($sformatf("c%0d sr_e_idle", gi), sr_e, exp_primed);
          if (rd_valid) begin
            if (word_q.size() == 0) begin
              chk($sformatf("c%0d unexpected_rd_valid", gi), 1, 0);
            end else begin
              w = word_q.pop_front();
              r = rd_q.pop_front();
              a = acc_q.pop_front();
              chk($sformatf("c%0d rd_data", gi), rd_data, r);
              chk($sformatf("c%0d chain_p_out", gi), chain, w);
              chk($sformatf("c%0d latency", gi), cyc - a, LAT);
              chk($sformatf("c%0d cp_pulses", gi), pulses, W);
            end
            pulses = 0;
            exp_primed = 1'b1;
          end
          prev_cp = sr_cp;
          prev_data = sr_data;
        end
      end
    end

    // Stimulus: directed words, backpressure, mid-shift reset, then random loads.
    initial begin
      int n;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      issue(D0);
      wait_idle();
      issue(D1);
      wait_idle();
      backpressure(W'(64'h155), W'($urandom));
      wait_idle();
      issue(W'($urandom));
      n = 0;
      while (pulses < 4 && n < 4 * LAT) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d abort_reached", gi), (pulses >= 4), 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      word_q.delete();
      rd_q.delete();
      acc_q.delete();
      exp_chain = chain;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(W'($urandom));
      wait_idle();
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        issue(W'($urandom));
        if ($urandom_range(0, 1) == 0) wait_idle();
      end
      wait_idle();
      repeat (3) @(negedge clk);
      done_flag[gi] = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(done_flag[0] && done_flag[1] && done_flag[2]) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 60000) chk("overall_timeout", 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
